score_judge: RTL and testbench

//  Game-side producer of the scoreboard interface: shows a finger pattern, samples the

---
 rtl/score_judge_pkg.sv | 16 +
 rtl/pattern_lfsr.sv | 14 +
 rtl/score_judge.sv | 112 +++++++++++
 tb/tb_score_judge.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/score_judge_pkg.sv
// score_judge_pkg: shared types, widths and LFSR helpers for the finger game judge
package score_judge_pkg;
  localparam int PAT_W = 4;
  localparam int SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;
  localparam logic [PAT_W-1:0] BLANK_PAT = 4'b0000;
  typedef enum logic [2:0] {IDLE = 3'd0, GAP = 3'd1, SHOW = 3'd2, JUDGE = 3'd3, OVER = 3'd4} state_t;
  // Fibonacci step, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction
  // a shown pattern is never blank
  function automatic logic [PAT_W-1:0] show_pat(input logic [7:0] q);
    return q[3:0] == 4'd0 ? 4'b0001 : q[3:0];
  endfunction
endpackage

// File: rtl/pattern_lfsr.sv
// pattern_lfsr: 8-bit Fibonacci LFSR (clk, res async active-low, step, seed -> q)
module pattern_lfsr
  import score_judge_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge res)
    if (!res) q <= seed;
    else if (step) q <= lfsr_next(q);
endmodule

// File: rtl/score_judge.sv
// score_judge: shows a finger pattern, judges timed button answers, keeps score (ports clk,res,start,btn -> pattern,score,C,hit,miss,over; optional COMBO_BONUS_EN streak bonus)
module score_judge
  import score_judge_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned MISS_LIMIT    = 3,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic               clk,
  input  logic               res,
  input  logic               start,
  input  logic [PAT_W-1:0]   btn,
  output logic [PAT_W-1:0]   pattern,
  output logic [SCORE_W-1:0] score,
  output logic               C,
  output logic               hit,
  output logic               miss,
  output logic               over
);
  localparam logic [3:0] MISS_MAX = MISS_LIMIT[3:0];
  state_t state;
  logic [PAT_W-1:0] btn_m, btn_s;
  logic [31:0] cnt;
  logic arm;
  logic [3:0] mcnt;
  logic [7:0] q;
  logic to_show, capture, timeout, judge, is_hit, new_game;
  logic [1:0] add;
  logic [SCORE_W:0] sum;
  logic [SCORE_W-1:0] score_inc;
  pattern_lfsr u_lfsr (.clk(clk), .res(res), .step(to_show), .seed(LFSR_SEED), .q(q));
`ifdef COMBO_BONUS_EN
  logic [2:0] streak;
  always_ff @(posedge clk or negedge res)
    if (!res) streak <= 3'd0;
    else if (new_game || (judge && !is_hit)) streak <= 3'd0;
    else if (judge && streak != 3'd4) streak <= streak + 3'd1;
  // the hit being judged is the 4th or later of the streak
  assign add = streak >= 3'd3 ? 2'd2 : 2'd1;
`else
  assign add = 2'd1;
`endif
  always_comb begin
    to_show   = state == GAP && cnt == GAP_CYCLES - 1;
    capture   = state == SHOW && arm && btn_s != BLANK_PAT;
    timeout   = state == SHOW && cnt == WINDOW_CYCLES - 1;
    judge     = capture || timeout;
    is_hit    = capture && btn_s == pattern;
    new_game  = start && (state == IDLE || state == OVER);
    sum       = {1'b0, score} + {7'd0, add};
    score_inc = sum > {1'b0, SCORE_MAX} ? SCORE_MAX : sum[SCORE_W-1:0];
  end
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      state   <= IDLE;
      btn_m   <= '0;
      btn_s   <= '0;
      cnt     <= '0;
      arm     <= 1'b0;
      mcnt    <= '0;
      pattern <= BLANK_PAT;
      score   <= '0;
      C       <= 1'b0;
      hit     <= 1'b0;
      miss    <= 1'b0;
      over    <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      hit   <= 1'b0;
      miss  <= 1'b0;
      case (state)
        IDLE, OVER:
          if (start) begin
            state <= GAP;
            cnt   <= '0;
            score <= '0;
            mcnt  <= '0;
            C     <= 1'b0;
            over  <= 1'b0;
          end
        GAP:
          if (to_show) begin
            state   <= SHOW;
            cnt     <= '0;
            arm     <= 1'b0;
            pattern <= show_pat(lfsr_next(q));
          end else cnt <= cnt + 32'd1;
        SHOW:
          // capture wins over a timeout in the same cycle (is_hit needs capture)
          if (judge) begin
            state <= JUDGE;
            hit   <= is_hit;
            miss  <= !is_hit;
            C     <= is_hit;
            if (is_hit) score <= score_inc;
            else mcnt <= mcnt + 4'd1;
          end else begin
            cnt <= cnt + 32'd1;
            if (btn_s == BLANK_PAT) arm <= 1'b1;
          end
        JUDGE: begin
          cnt     <= '0;
          pattern <= BLANK_PAT;
          state   <= mcnt == MISS_MAX ? OVER : GAP;
          over    <= mcnt == MISS_MAX;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_score_judge.sv
// tb_score_judge: directed table-driven bench for score_judge
module tb_score_judge;
  logic clk = 1'b0, res = 1'b0, start = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [3:0] pattern;
  logic [7:0] score;
  logic C, hit, miss, over;
  int nvec = 0, nerr = 0;
  logic [7:0] m = 8'hA5;

  typedef enum {M_EXACT, M_NONE, M_HOLD, M_HREL, M_EXTRA, M_WRONG} mode_t;
  typedef struct {
    logic       ns;
    mode_t      md;
    logic [3:0] pat;
    logic       eh;
    logic [7:0] es;
    logic       eo;
  } vec_t;
  vec_t tbl[9];

  score_judge #(.WINDOW_CYCLES(20), .GAP_CYCLES(4), .MISS_LIMIT(3), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .res(res), .start(start), .btn(btn), .pattern(pattern),
    .score(score), .C(C), .hit(hit), .miss(miss), .over(over)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lf_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  function automatic logic [3:0] shw(input logic [7:0] v);
    return v[3:0] == 4'd0 ? 4'd1 : v[3:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // precondition: sampled just after the edge that entered GAP
  task automatic play(input mode_t md, input logic [3:0] tpat, input logic eh,
                      input logic [7:0] es, input logic ck, input logic eo);
    logic [3:0] ep;
    logic z;
    int n;
    m = lf_next(m);
    ep = tpat != 4'd0 ? tpat : shw(m);
    if (md == M_HOLD || md == M_HREL) btn = ep;
    z = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      z &= pattern == 4'd0;
    end
    chk("gap_blank", 32'(z), 32'd1);
    tick();
    chk("show_pat", 32'(pattern), 32'(ep));
    case (md)
      M_EXACT: btn = ep;
      M_EXTRA: btn = ep | 4'b1000;
      M_WRONG: btn = ~ep;
      default: ;
    endcase
    n = 0;
    while (n < 40 && !(hit || miss)) begin
      tick();
      n++;
      if (md == M_HREL && n == 2) btn = 4'd0;
      if (md == M_HREL && n == 6) btn = ep;
      start = md == M_NONE && n == 5;
    end
    start = 1'b0;
    chk("judge_seen", 32'(n < 40), 32'd1);
    if (md == M_NONE || md == M_HOLD) chk("timeout_latency", 32'(n), 32'd20);
    chk("hit", 32'(hit), 32'(eh));
    chk("miss", 32'(miss), 32'(!eh));
    chk("C", 32'(C), 32'(eh));
    if (ck) chk("score", 32'(score), 32'(es));
    btn = 4'd0;
    tick();
    chk("over", 32'(over), 32'(eo));
    chk("blank_after", 32'(pattern), 32'd0);
  endtask

  initial begin
    int cs[7];
    logic z;
    tbl[0] = '{1'b1, M_EXACT, 4'hA, 1'b1, 8'd1, 1'b0};
    tbl[1] = '{1'b0, M_NONE,  4'h5, 1'b0, 8'd1, 1'b0};
    tbl[2] = '{1'b0, M_NONE,  4'hA, 1'b0, 8'd1, 1'b0};
    tbl[3] = '{1'b0, M_NONE,  4'h4, 1'b0, 8'd1, 1'b1};
    tbl[4] = '{1'b1, M_HOLD,  4'h9, 1'b0, 8'd0, 1'b0};
    tbl[5] = '{1'b0, M_HREL,  4'h3, 1'b1, 8'd1, 1'b0};
    tbl[6] = '{1'b0, M_EXTRA, 4'h7, 1'b0, 8'd1, 1'b0};
    tbl[7] = '{1'b0, M_EXACT, 4'hE, 1'b1, 8'd2, 1'b0};
    tbl[8] = '{1'b0, M_WRONG, 4'hD, 1'b0, 8'd2, 1'b1};
`ifdef COMBO_BONUS_EN
    cs = '{1, 2, 3, 5, 7, 7, 8};
`else
    cs = '{1, 2, 3, 4, 5, 5, 6};
`endif
    #12;
    chk("reset_outputs", 32'({pattern, score, C, hit, miss, over}), 32'd0);
    #3 res = 1'b1;
    z = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      z &= pattern == 4'd0 && !over && !hit && !miss;
    end
    chk("idle_quiet", 32'(z), 32'd1);
    for (int r = 0; r < 9; r++) begin
      if (tbl[r].ns) go();
      play(tbl[r].md, tbl[r].pat, tbl[r].eh, tbl[r].es, 1'b1, tbl[r].eo);
    end
    go();
    for (int i = 1; i <= 256; i++)
      play(M_EXACT, 4'd0, 1'b1, 8'hFF, i >= 255, 1'b0);
    repeat (6) tick();
    chk("mid_show_pattern_up", 32'(pattern != 4'd0), 32'd1);
    #2 res = 1'b0;
    #1 chk("async_reset_outputs", 32'({pattern, score, C, hit, miss, over}), 32'd0);
    #1 res = 1'b1;
    m = 8'hA5;
    z = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      z &= pattern == 4'd0 && !over && !hit && !miss && score == 8'd0;
    end
    chk("idle_after_reset", 32'(z), 32'd1);
    go();
    for (int i = 0; i < 5; i++) play(M_EXACT, 4'd0, 1'b1, 8'(cs[i]), 1'b1, 1'b0);
    play(M_NONE, 4'd0, 1'b0, 8'(cs[5]), 1'b1, 1'b0);
    play(M_EXACT, 4'd0, 1'b1, 8'(cs[6]), 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
